// File: rtl/pc_sequencer_pkg.sv
// Shared types and sizes for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int unsigned FLUSH_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the architectural PC: sequential advance, branch redirect with a
// fixed-length flush, halt, and saturating taken/not-taken statistics.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned            PC_STEP      = 1,
    parameter int unsigned            FLUSH_CYCLES = 2,
    parameter int unsigned            STAT_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  advance,
    input  logic                  branch_valid,
    input  logic                  take,
    input  logic                  absolute,
    input  logic [ADDR_WIDTH-1:0] branch_pc,
    input  logic [ADDR_WIDTH-1:0] branch_offset,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  flush,
    output logic                  halted,
    output logic [STAT_WIDTH-1:0] taken_count,
    output logic [STAT_WIDTH-1:0] not_taken_count
);

    localparam logic [ADDR_WIDTH-1:0]      STEP      = ADDR_WIDTH'(PC_STEP);
    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LEN = FLUSH_CNT_WIDTH'(FLUSH_CYCLES);

    seq_state_e                 state;
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt;
    logic [ADDR_WIDTH-1:0]      target_c;
    logic                       resolve_c;
    logic                       taken_en_c;
    logic                       not_taken_en_c;

    // Branch statistics only count branches resolved while actually sequencing.
    assign target_c       = absolute ? branch_target : (branch_pc + branch_offset);
    assign resolve_c      = !stall && (state == RUN) && branch_valid;
    assign taken_en_c     = resolve_c && take;
    assign not_taken_en_c = resolve_c && !take;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc        <= RESET_VECTOR;
            state     <= RUN;
            flush     <= 1'b0;
            halted    <= 1'b0;
            flush_cnt <= '0;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    if (branch_valid && take) begin
                        pc        <= target_c;
                        flush_cnt <= FLUSH_LEN;
                        flush     <= 1'b1;
                        state     <= FLUSH;
                    end else if (halt) begin
                        halted <= 1'b1;
                        state  <= HALTED;
                    end else if (advance) begin
                        pc <= pc + STEP;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - FLUSH_CNT_WIDTH'(1);
                    // Last flush cycle: drop flush together with the return to RUN.
                    if (flush_cnt == FLUSH_CNT_WIDTH'(1)) begin
                        flush <= 1'b0;
                        state <= RUN;
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                    flush  <= 1'b0;
                end
                default: begin
                    flush <= 1'b0;
                    state <= RUN;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(STAT_WIDTH)) u_taken_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (taken_en_c),
        .count  (taken_count)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_not_taken_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (not_taken_en_c),
        .count  (not_taken_count)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized check of pc_sequencer against a behavioural model;
// a second instance with 4-bit statistics shares the stimulus.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        advance;
    logic        branch_valid;
    logic        take;
    logic        absolute;
    logic [31:0] branch_pc;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic        halt;

    logic [31:0] pc;
    logic        flush;
    logic        halted;
    logic [15:0] taken_count;
    logic [15:0] not_taken_count;
    logic [31:0] pc4;
    logic        flush4;
    logic        halted4;
    logic [3:0]  taken_count4;
    logic [3:0]  not_taken_count4;

    int tests;
    int fails;

    // Reference model: remaining flush cycles and plain counts.
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_halted;
    int          m_taken;
    int          m_not_taken;

    pc_sequencer dut (
        .clock           (clk),
        .reset           (reset),
        .stall           (stall),
        .advance         (advance),
        .branch_valid    (branch_valid),
        .take            (take),
        .absolute        (absolute),
        .branch_pc       (branch_pc),
        .branch_offset   (branch_offset),
        .branch_target   (branch_target),
        .halt            (halt),
        .pc              (pc),
        .flush           (flush),
        .halted          (halted),
        .taken_count     (taken_count),
        .not_taken_count (not_taken_count)
    );

    pc_sequencer #(.STAT_WIDTH(4)) dut4 (
        .clock           (clk),
        .reset           (reset),
        .stall           (stall),
        .advance         (advance),
        .branch_valid    (branch_valid),
        .take            (take),
        .absolute        (absolute),
        .branch_pc       (branch_pc),
        .branch_offset   (branch_offset),
        .branch_target   (branch_target),
        .halt            (halt),
        .pc              (pc4),
        .flush           (flush4),
        .halted          (halted4),
        .taken_count     (taken_count4),
        .not_taken_count (not_taken_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            m_pc = 32'h0; m_flush_left = 0; m_halted = 0; m_taken = 0; m_not_taken = 0;
        end else if (!stall && !m_halted) begin
            if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (branch_valid && take) begin
                m_pc = absolute ? branch_target : branch_pc + branch_offset;
                m_flush_left = 2;
                m_taken++;
            end else begin
                if (branch_valid) m_not_taken++;
                if (halt) m_halted = 1;
                else if (advance) m_pc = m_pc + 32'd1;
            end
        end
    endtask

    task automatic check_all();
        check("pc", 64'(pc), 64'(m_pc));
        check("flush", 64'(flush), 64'(m_flush_left > 0));
        check("halted", 64'(halted), 64'(m_halted));
        check("taken16", 64'(taken_count), 64'(sat(m_taken, 65535)));
        check("not_taken16", 64'(not_taken_count), 64'(sat(m_not_taken, 65535)));
        check("taken4", 64'(taken_count4), 64'(sat(m_taken, 15)));
        check("not_taken4", 64'(not_taken_count4), 64'(sat(m_not_taken, 15)));
        check("pc4", 64'(pc4), 64'(m_pc));
    endtask

    // One clock: inputs already driven; update model at the edge, sample after.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        reset = 1'b1; stall = 1'b0; advance = 1'b0; branch_valid = 1'b0; take = 1'b0;
        absolute = 1'b0; branch_pc = '0; branch_offset = '0; branch_target = '0; halt = 1'b0;
    endtask

    task automatic taken_abs(input logic [31:0] tgt);
        branch_valid = 1'b1; take = 1'b1; absolute = 1'b1; branch_target = tgt;
        step();
        branch_valid = 1'b0; take = 1'b0;
    endtask

    initial begin
        int fl;
        tests = 0; fails = 0;
        m_pc = '0; m_flush_left = 0; m_halted = 0; m_taken = 0; m_not_taken = 0;
        idle();

        reset = 1'b0;
        step();
        check("reset_pc", 64'(pc), 64'h0);
        reset = 1'b1;

        advance = 1'b1;
        repeat (3) step();
        check("seq_pc3", 64'(pc), 64'h3);
        repeat (13) step();
        check("seq_pc10", 64'(pc), 64'h10);

        // Relative backward branch from 0x10 by -8.
        advance = 1'b0; branch_valid = 1'b1; take = 1'b1; absolute = 1'b0;
        branch_pc = 32'h10; branch_offset = 32'hFFFF_FFF8;
        step();
        check("rel_target", 64'(pc), 64'h8);
        check("rel_flush", 64'(flush), 64'h1);
        branch_valid = 1'b0; take = 1'b0;
        step();
        check("rel_flush2", 64'(flush), 64'h1);
        step();
        check("rel_flush_end", 64'(flush), 64'h0);
        advance = 1'b1;
        step();
        check("rel_first_adv", 64'(pc), 64'h9);
        check("rel_taken", 64'(taken_count), 64'h1);

        // Absolute branch; a second taken branch during flush is ignored.
        taken_abs(32'h400);
        check("abs_target", 64'(pc), 64'h400);
        branch_valid = 1'b1; take = 1'b1; absolute = 1'b1; branch_target = 32'h123;
        step();
        step();
        check("abs_ignored", 64'(pc), 64'h400);
        check("abs_taken", 64'(taken_count), 64'h2);
        branch_valid = 1'b0; take = 1'b0;

        // Reach pc=5, then a not-taken branch with advance.
        advance = 1'b0;
        taken_abs(32'h5);
        step(); step();
        advance = 1'b1; branch_valid = 1'b1; take = 1'b0;
        step();
        check("nt_pc", 64'(pc), 64'h6);
        check("nt_flush", 64'(flush), 64'h0);
        check("nt_count", 64'(not_taken_count), 64'h1);
        branch_valid = 1'b0;

        // Stall for 3 cycles inside a flush window.
        fl = 0;
        taken_abs(32'h20);
        fl += int'(flush);
        stall = 1'b1;
        repeat (3) begin step(); fl += int'(flush); end
        stall = 1'b0;
        repeat (3) begin step(); fl += int'(flush); end
        check("stall_flush_len", 64'(fl), 64'd5);
        check("stall_pc", 64'(pc), 64'h21);

        // Branch beats halt; a later halt freezes pc under advance.
        halt = 1'b1;
        taken_abs(32'h50);
        check("halt_vs_branch", 64'(halted), 64'h0);
        halt = 1'b0; advance = 1'b0;
        step(); step();
        halt = 1'b1;
        step();
        check("halted_set", 64'(halted), 64'h1);
        halt = 1'b0; advance = 1'b1;
        repeat (3) step();
        check("halted_pc", 64'(pc), 64'h50);
        reset = 1'b0;
        step();
        check("reset_exit_pc", 64'(pc), 64'h0);
        check("reset_exit_halted", 64'(halted), 64'h0);
        reset = 1'b1;

        // 20 taken branches saturate the 4-bit counter.
        advance = 1'b0;
        for (int i = 0; i < 20; i++) begin
            taken_abs(32'(i * 4));
            step(); step();
        end
        check("sat_taken4", 64'(taken_count4), 64'hF);
        check("sat_taken16", 64'(taken_count), 64'd20);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(99) >= 2);
            stall         = ($urandom_range(99) < 10);
            advance       = ($urandom_range(1) == 1);
            branch_valid  = ($urandom_range(99) < 40);
            take          = ($urandom_range(1) == 1);
            absolute      = ($urandom_range(1) == 1);
            branch_pc     = $urandom;
            branch_offset = ($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(64)) - 32'd32;
            branch_target = $urandom;
            halt          = ($urandom_range(99) < 3);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
